// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_run_ctrl
// Description : Run controller for the RV32I core. It sequences the core
//               reset, counts cycles and retired instructions, watches for a
//               tohost halt write and applies a cycle-budget watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module core_run_ctrl #(
    parameter int                CNT_W       = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                RST_HOLD    = 4,
    parameter int                TIMEOUT     = 12000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic              retire,
    output logic              core_reset_n,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycles,
    output logic [CNT_W-1:0]  instret
);

    localparam int                HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  c_TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_clear;
    logic                w_halt;
    logic                w_wdog;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_core_reset_n;
    logic                r_running;
    logic                r_done;
    logic                r_pass;
    logic                r_fail;
    logic                r_timeout;
    logic [DATA_W-2:0]   r_fail_code;
    logic [CNT_W-1:0]    r_cycles;
    logic [CNT_W-1:0]    r_instret;

    assign w_halt = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);
    assign w_wdog = (r_cycles == c_TO_LAST);

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_HOLD;
                    w_clear = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_halt || w_wdog) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next  = S_HOLD;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Level outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_hold_cnt     <= '0;
            r_core_reset_n <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fail_code    <= '0;
            r_cycles       <= '0;
            r_instret      <= '0;
        end else begin
            r_state        <= w_next;
            r_core_reset_n <= (w_next == S_RUN);
            r_running      <= (w_next == S_RUN);
            r_done         <= (w_next == S_DONE);
            if (w_clear) begin
                r_hold_cnt  <= c_HOLD_LOAD;
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_timeout   <= 1'b0;
                r_fail_code <= '0;
                r_cycles    <= '0;
                r_instret   <= '0;
            end else if (r_state == S_HOLD) begin
                if (r_hold_cnt != '0) begin
                    r_hold_cnt <= r_hold_cnt - 1'b1;
                end
            end else if (r_state == S_RUN) begin
                if (r_cycles != c_CNT_MAX) begin
                    r_cycles <= r_cycles + 1'b1;
                end
                if (retire && (r_instret != c_CNT_MAX)) begin
                    r_instret <= r_instret + 1'b1;
                end
                // A halt write wins over a watchdog expiry in the same cycle.
                if (w_halt) begin
                    if (dmem_wdata == DATA_W'(1)) begin
                        r_pass <= 1'b1;
                    end else begin
                        r_fail      <= 1'b1;
                        r_fail_code <= dmem_wdata[DATA_W-1:1];
                    end
                end else if (w_wdog) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign core_reset_n = r_core_reset_n;
    assign running      = r_running;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign fail_code    = r_fail_code;
    assign cycles       = r_cycles;
    assign instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_run_ctrl
// Description : Directed self-checking bench for core_run_ctrl with a
//               scoreboard of expected output snapshots.
// Revision    : 1.0  initial release
// ============================================================================
module tb_core_run_ctrl;

    localparam int c_RST_HOLD = 4;
    localparam int c_TIMEOUT  = 50;

    logic        clk;
    logic        reset;
    logic        start;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        retire;
    logic        core_reset_n;
    logic        running;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycles;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        crn;
        logic        run;
        logic        dn;
        logic        ps;
        logic        fl;
        logic        to;
        logic [30:0] fc;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    core_run_ctrl #(
        .CNT_W      (32),
        .ADDR_W     (32),
        .DATA_W     (32),
        .RST_HOLD   (c_RST_HOLD),
        .TIMEOUT    (c_TIMEOUT),
        .TOHOST_ADDR(32'h0000_1000)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .retire      (retire),
        .core_reset_n(core_reset_n),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycles      (cycles),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic crn, input logic run,
                        input logic dn, input logic ps, input logic fl,
                        input logic to, input logic [30:0] fc,
                        input logic [31:0] cyc, input logic [31:0] ins);
        exp_t e;
        e.tag = tag; e.crn = crn; e.run = run; e.dn = dn; e.ps = ps;
        e.fl = fl; e.to = to; e.fc = fc; e.cyc = cyc; e.ins = ins;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".core_reset_n"}, 32'(core_reset_n), 32'(e.crn));
        cmp({e.tag, ".running"},      32'(running),      32'(e.run));
        cmp({e.tag, ".done"},         32'(done),         32'(e.dn));
        cmp({e.tag, ".pass"},         32'(pass),         32'(e.ps));
        cmp({e.tag, ".fail"},         32'(fail),         32'(e.fl));
        cmp({e.tag, ".timeout"},      32'(timeout),      32'(e.to));
        cmp({e.tag, ".fail_code"},    32'(fail_code),    32'(e.fc));
        cmp({e.tag, ".cycles"},       cycles,            e.cyc);
        cmp({e.tag, ".instret"},      instret,           e.ins);
    endtask

    task automatic idle_bus();
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        retire     = 1'b0;
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        dmem_we    = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = data;
    endtask

    // Start a run and walk through HOLD into the first RUN cycle.
    task automatic start_run(input string tag);
        start = 1'b1;
        push({tag, ".hold_enter"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_next();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        push({tag, ".hold_end"}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_next();
        push({tag, ".run_enter"}, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_next();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        idle_bus();

        for (int i = 0; i < 3; i++) begin
            push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            check_next();
        end
        reset = 1'b0;
        start = 1'b0;
        push("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_next();

        // Pass run: 20 RUN cycles, 12 retires, start pulse ignored mid-run.
        start_run("pass");
        for (int i = 0; i < 20; i++) begin
            retire = (i < 12);
            start  = (i == 5);
            tick();
        end
        start  = 1'b0;
        retire = 1'b0;
        push("pass.run20", 1, 1, 0, 0, 0, 0, 0, 20, 12);
        check_next();
        mem_write(32'h1000, 32'h1);
        push("pass.halt", 0, 0, 1, 1, 0, 0, 0, 21, 12);
        tick();
        check_next();
        mem_write(32'h1000, 32'h7);
        retire = 1'b1;
        tick();
        push("pass.done_hold", 0, 0, 1, 1, 0, 0, 0, 21, 12);
        tick();
        check_next();
        idle_bus();

        // Fail run: zero tohost and wrong address ignored, retire in halt cycle.
        start_run("fail");
        retire = 1'b1;
        mem_write(32'h1000, 32'h0);
        tick();
        mem_write(32'h1004, 32'h1);
        tick();
        idle_bus();
        push("fail.ignored", 1, 1, 0, 0, 0, 0, 0, 2, 2);
        check_next();
        for (int i = 0; i < 3; i++) tick();
        retire = 1'b1;
        mem_write(32'h1000, 32'h7);
        push("fail.halt", 0, 0, 1, 0, 1, 0, 31'd3, 6, 3);
        tick();
        check_next();
        idle_bus();

        // Watchdog expiry.
        start_run("tmo");
        for (int i = 0; i < c_TIMEOUT - 1; i++) tick();
        push("tmo.last_run", 1, 1, 0, 0, 0, 0, 0, 49, 0);
        check_next();
        push("tmo.expire", 0, 0, 1, 0, 0, 1, 0, 50, 0);
        tick();
        check_next();

        // Halt write on the watchdog cycle wins.
        start_run("race");
        for (int i = 0; i < c_TIMEOUT - 1; i++) tick();
        mem_write(32'h1000, 32'h1);
        push("race.halt", 0, 0, 1, 1, 0, 0, 0, 50, 0);
        tick();
        check_next();
        idle_bus();

        // Reset asserted mid-run.
        start_run("mrst");
        retire = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        retire = 1'b0;
        push("mrst.run5", 1, 1, 0, 0, 0, 0, 0, 5, 5);
        check_next();
        reset = 1'b1;
        push("mrst.reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_next();
        reset = 1'b0;
        push("mrst.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_next();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
